// File: rtl/split_initiator_port.sv
// split_initiator_port
//
// Bus initiator port that supports split transactions. A request from the
// local initiator is latched, the bus is requested from the arbiter, and the
// 12-bit address is shifted out serially, LSB first. After the address, the
// target either accepts it (ack) or defers the read data (split).
//   - On a write, 8 data bits are shifted out.
//   - On a read, 8 data bits are collected from the target.
// A split read releases the bus until the arbiter re-grants it through
// split_grant. While waiting for an ack or for read data, a 5-bit idle
// counter aborts the transaction with an error after 32 idle cycles.
// Every output is registered.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   init_req/addr/wdata/rw
//                       request from the local initiator (sampled in IDLE)
//   init_rdata/_valid, init_done, init_error, init_busy, init_split
//                       status back to the local initiator
//   arbiter_req, arbiter_grant, split_grant
//                       arbiter handshake
//   bus_data_out/_valid, bus_mode, bus_rw
//                       serial address/write-data lane toward the target
//   bus_target_ack, bus_split_ack, bus_data_in/_valid
//                       target responses and serial read data
module split_initiator_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic [11:0] init_addr,
  input  logic [7:0]  init_wdata,
  input  logic        init_rw,
  input  logic        arbiter_grant,
  input  logic        split_grant,
  input  logic        bus_target_ack,
  input  logic        bus_split_ack,
  input  logic        bus_data_in,
  input  logic        bus_data_in_valid,
  output logic        arbiter_req,
  output logic        bus_data_out,
  output logic        bus_data_out_valid,
  output logic        bus_mode,
  output logic        bus_rw,
  output logic [7:0]  init_rdata,
  output logic        init_rdata_valid,
  output logic        init_done,
  output logic        init_error,
  output logic        init_busy,
  output logic        init_split
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_ACK_WAIT,
    S_WDATA,
    S_RDATA,
    S_SPLIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [11:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  tmo_q, tmo_d;
  logic [7:0]  rbuf_q, rbuf_d;

  logic        arb_req_q, arb_req_d;
  logic        dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        mode_q, mode_d;
  logic        bus_rw_q, bus_rw_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        split_q, split_d;

  // Next-state and next-output logic. The outputs are derived from the
  // *next* state, so each registered output describes the state that
  // becomes current on the same edge. The serial output bit is always
  // shift_d[0]: a freshly loaded shifter presents bit 0 in the first
  // cycle, and each following cycle shifts right by one position.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rw_d          = rw_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_d         = tmo_q;
    rbuf_d        = rbuf_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    error_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_req) begin
          addr_d  = init_addr;
          wdata_d = init_wdata;
          rw_d    = init_rw;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (arbiter_grant) begin
          shift_d   = addr_q;
          bit_cnt_d = 4'd0;
          state_d   = S_ADDR;
        end
      end

      S_ADDR: begin
        shift_d = shift_q >> 1;
        if (bit_cnt_q == 4'd11) begin
          tmo_d   = 5'd0;
          state_d = S_ACK_WAIT;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end

      // Ack takes priority over split. A split on a write is meaningless,
      // so it is ignored and the idle counter keeps running.
      S_ACK_WAIT: begin
        if (bus_target_ack) begin
          bit_cnt_d = 4'd0;
          if (rw_q) begin
            shift_d = {4'b0000, wdata_q};
            state_d = S_WDATA;
          end else begin
            tmo_d   = 5'd0;
            rbuf_d  = 8'd0;
            state_d = S_RDATA;
          end
        end else if (bus_split_ack && !rw_q) begin
          state_d = S_SPLIT;
        end else if (tmo_q == 5'd31) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 5'd1;
        end
      end

      S_WDATA: begin
        shift_d = shift_q >> 1;
        if (bit_cnt_q == 4'd7) begin
          state_d = S_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end

      // The published byte includes the bit captured on this same edge,
      // so it is taken from rbuf_d rather than rbuf_q.
      S_RDATA: begin
        if (bus_data_in_valid) begin
          rbuf_d[bit_cnt_q[2:0]] = bus_data_in;
          tmo_d = 5'd0;
          if (bit_cnt_q == 4'd7) begin
            rdata_d       = rbuf_d;
            rdata_valid_d = 1'b1;
            state_d       = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tmo_q == 5'd31) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 5'd1;
        end
      end

      // A deferred target may take arbitrarily long, so there is no
      // timeout here.
      S_SPLIT: begin
        if (split_grant) begin
          bit_cnt_d = 4'd0;
          tmo_d     = 5'd0;
          rbuf_d    = 8'd0;
          state_d   = S_RDATA;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    arb_req_d    = (state_d == S_REQ) || (state_d == S_ADDR) ||
                   (state_d == S_ACK_WAIT) || (state_d == S_WDATA) ||
                   (state_d == S_RDATA);
    dout_valid_d = (state_d == S_ADDR) || (state_d == S_WDATA);
    dout_d       = dout_valid_d ? shift_d[0] : 1'b0;
    mode_d       = (state_d == S_ADDR);
    bus_rw_d     = (state_d != S_IDLE) ? rw_d : 1'b0;
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    split_d      = (state_d == S_SPLIT);
  end

  // State and output registers. Reset returns everything to zero,
  // including the last read byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rw_q          <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
      rbuf_q        <= '0;
      arb_req_q     <= 1'b0;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      mode_q        <= 1'b0;
      bus_rw_q      <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      split_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rw_q          <= rw_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_q         <= tmo_d;
      rbuf_q        <= rbuf_d;
      arb_req_q     <= arb_req_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      mode_q        <= mode_d;
      bus_rw_q      <= bus_rw_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
      split_q       <= split_d;
    end
  end

  assign arbiter_req        = arb_req_q;
  assign bus_data_out       = dout_q;
  assign bus_data_out_valid = dout_valid_q;
  assign bus_mode           = mode_q;
  assign bus_rw             = bus_rw_q;
  assign init_rdata         = rdata_q;
  assign init_rdata_valid   = rdata_valid_q;
  assign init_done          = done_q;
  assign init_error         = error_q;
  assign init_busy          = busy_q;
  assign init_split         = split_q;

endmodule

// File: doc/split_initiator_port.md
SPLIT_INITIATOR_PORT -- requirements
Module: split_initiator_port

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high; sampled on rising edge of clk.
REQ-003 init_req  in  1  start pulse from initiator; sampled only in IDLE.
REQ-004 init_addr  in  12  transaction address; latched with init_req.
REQ-005 init_wdata  in  8  write data; latched with init_req.
REQ-006 init_rw  in  1  1 = write, 0 = read; latched with init_req.
REQ-007 arbiter_grant  in  1  bus granted to this initiator.
REQ-008 split_grant  in  1  arbiter re-grant after a split; target has read data ready.
REQ-009 bus_target_ack  in  1  target accepted the address.
REQ-010 bus_split_ack  in  1  target defers read data (split).
REQ-011 bus_data_in  in  1  serial read data from target, LSB first.
REQ-012 bus_data_in_valid  in  1  qualifies bus_data_in, one bit per cycle.
REQ-013 arbiter_req  out  1  bus request to arbiter.
REQ-014 bus_data_out  out  1  serial address/write data, LSB first.
REQ-015 bus_data_out_valid  out  1  qualifies bus_data_out.
REQ-016 bus_mode  out  1  1 = address phase, 0 = data phase.
REQ-017 bus_rw  out  1  latched init_rw while a transaction is active, else 0.
REQ-018 init_rdata  out  8  assembled read byte.
REQ-019 init_rdata_valid / init_done / init_error  out  1 each  single-cycle completion strobes.
REQ-020 init_busy / init_split  out  1 each  state not IDLE / state is SPLIT.

Function
REQ-021 States SHALL be IDLE, REQ, ADDR, ACK_WAIT, WDATA, RDATA, SPLIT, DONE; all outputs registered.
REQ-022 IDLE: on init_req=1, latch addr/wdata/rw and go to REQ; init_req outside IDLE is ignored.
REQ-023 REQ: arbiter_req=1; on arbiter_grant=1, load the 12-bit address shifter and go to ADDR.
REQ-024 ADDR: drive addr[0]..addr[11] on 12 consecutive cycles with bus_data_out_valid=1 and bus_mode=1, then go to ACK_WAIT.
REQ-025 ACK_WAIT: bus_target_ack=1 goes to WDATA (write) or RDATA (read); for a read, bus_split_ack=1 goes to SPLIT; ack wins if both are high; bus_split_ack during a write is ignored.
REQ-026 WDATA: drive wdata[0]..wdata[7] on 8 consecutive cycles with bus_data_out_valid=1 and bus_mode=0, then go to DONE.
REQ-027 RDATA: each cycle with bus_data_in_valid=1 stores one bit at index bit_cnt (0..7, LSB first); after the 8th bit, go to DONE with the assembled byte.
REQ-028 SPLIT: arbiter_req=0 and init_split=1; on split_grant=1, clear bit_cnt and go to RDATA with arbiter_req=1; no timeout in SPLIT.
REQ-029 arbiter_req SHALL be 1 in REQ, ADDR, ACK_WAIT, WDATA and RDATA, and 0 in IDLE, SPLIT and DONE.
REQ-030 Timeout: a 5-bit counter clears on entry to ACK_WAIT or RDATA and on each valid input bit; the 32nd consecutive idle cycle goes to DONE with an error.
REQ-031 DONE: for one cycle, pulse init_done=1; on a successful read, also update init_rdata and pulse init_rdata_valid=1; on a timeout, pulse init_error=1 and leave init_rdata unchanged; then go to IDLE.
REQ-032 bus_data_out_valid SHALL be 0 outside ADDR/WDATA; bus_data_out SHALL be 0 when not valid.
REQ-033 Latency: arbiter_req asserts 1 cycle after init_req; the first address bit appears 1 cycle after arbiter_grant is sampled.
REQ-034 A write with zero wait states takes 1 + 1 + 12 + 1 + 8 + 1 cycles from init_req to init_done.

Reset
REQ-035 When rst=1, state SHALL go to IDLE; all outputs, shifters and counters SHALL be 0, including init_rdata.
REQ-036 rst asserted mid-transaction (any state, including SPLIT) SHALL abort it with no init_done and arbiter_req=0 on the next cycle.

Verification
REQ-037 Write addr=0xA5C, data=0x3B, grant after 2 cycles, ack after 1 cycle -> serial address bits 0,0,1,1,1,0,1,0,0,1,0,1 with bus_mode=1, then 1,1,0,1,1,1,0,0 with bus_mode=0, then one init_done pulse.
REQ-038 Read, ack, bus_data_in bits 1,0,0,0,0,0,0,1 with 3 gap cycles interleaved -> init_rdata=0x81 and init_rdata_valid pulses for one cycle.
REQ-039 Read, bus_split_ack=1 -> arbiter_req=0 and init_split=1; split_grant after 20 cycles, then bits for 0x5A -> init_rdata=0x5A.
REQ-040 ACK_WAIT with neither ack nor split for 32 cycles -> init_error and init_done pulse together; init_rdata unchanged; state returns to IDLE.
REQ-041 rst=1 during the 5th address bit, and separately during SPLIT -> all outputs 0 the next cycle; a following init_req completes normally.
REQ-042 bus_target_ack and bus_split_ack high in the same cycle on a read -> RDATA entered, init_split never asserts.
